// File: rtl/display_scheduler.sv
// Two-source arbiter for a multiplexed 7-segment display. Updates from either
// source are deferred to frame boundaries, and a shown source keeps the display
// for a minimum number of frames.
module display_scheduler #(
  parameter int SCAN_DIV     = 100000,
  parameter int DWELL_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] numb0,
  input  logic [7:0]  mask0,
  input  logic        err0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] numb1,
  input  logic [7:0]  mask1,
  input  logic        err1,
  output logic        ack1,
  input  logic        clear,
  output logic [31:0] numb,
  output logic [7:0]  mask,
  output logic        error,
  output logic        scan_en,
  output logic [2:0]  digit,
  output logic        frame_start,
  output logic        owner,
  output logic        active
);

  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int DWW  = $clog2(DWELL_FRAMES + 1);
  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(SCAN_DIV - 1);
  localparam logic [DWW-1:0]  DWELL_MAX = DWW'(DWELL_FRAMES);

  typedef enum logic [1:0] {IDLE, PEND, SHOW} state_t;

  state_t          state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [2:0]      digit_q, digit_d;
  logic [DWW-1:0]  dwell_q, dwell_d;
  logic            clr_pend_q, clr_pend_d;
  logic            last_owner_q, last_owner_d;
  logic            owner_q, owner_d;
  logic            active_q, active_d;
  logic            gnt_src_q, gnt_src_d;
  logic [31:0]     sh_numb_q, sh_numb_d;
  logic [7:0]      sh_mask_q, sh_mask_d;
  logic            sh_err_q, sh_err_d;
  logic [31:0]     numb_q, numb_d;
  logic [7:0]      mask_q, mask_d;
  logic            err_q, err_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;

  logic scan_w, frame_w, blocked, eligible, gnt0, gnt1;

  assign scan_w   = (div_q == DIV_LAST);
  assign frame_w  = scan_w && (digit_q == 3'd7);
  // A clear arriving this cycle blocks grants just like a latched one.
  assign blocked  = clr_pend_q || clear;
  assign eligible = (state_q == IDLE) || ((state_q == SHOW) && (dwell_q == DWELL_MAX));

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!blocked) begin
      if (eligible) begin
        if (req0 && req1) begin
          gnt0 = last_owner_q;
          gnt1 = !last_owner_q;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end else if (state_q == SHOW) begin
        gnt0 = req0 && !owner_q;
        gnt1 = req1 && owner_q;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = scan_w ? '0 : div_q + DIVW'(1);
    digit_d      = scan_w ? digit_q + 3'd1 : digit_q;
    dwell_d      = dwell_q;
    clr_pend_d   = clr_pend_q || clear;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    active_d     = active_q;
    gnt_src_d    = gnt_src_q;
    sh_numb_d    = sh_numb_q;
    sh_mask_d    = sh_mask_q;
    sh_err_d     = sh_err_q;
    numb_d       = numb_q;
    mask_d       = mask_q;
    err_d        = err_q;
    ack0_d       = gnt0;
    ack1_d       = gnt1;

    if (gnt0 || gnt1) begin
      gnt_src_d = gnt1;
      sh_numb_d = gnt1 ? numb1 : numb0;
      sh_mask_d = gnt1 ? mask1 : mask0;
      sh_err_d  = gnt1 ? err1  : err0;
      state_d   = PEND;
    end

    // All visible changes happen on the frame wrap so a frame never tears.
    if (frame_w) begin
      if (blocked) begin
        numb_d     = '0;
        mask_d     = '1;
        err_d      = 1'b0;
        active_d   = 1'b0;
        clr_pend_d = 1'b0;
        state_d    = IDLE;
      end else if (state_q == PEND) begin
        numb_d       = sh_numb_q;
        mask_d       = sh_mask_q;
        err_d        = sh_err_q;
        owner_d      = gnt_src_q;
        last_owner_d = gnt_src_q;
        active_d     = 1'b1;
        dwell_d      = '0;
        state_d      = SHOW;
      end else if ((state_q == SHOW) && (dwell_q != DWELL_MAX)) begin
        dwell_d = dwell_q + DWW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      digit_q      <= '0;
      dwell_q      <= '0;
      clr_pend_q   <= 1'b0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      active_q     <= 1'b0;
      gnt_src_q    <= 1'b0;
      sh_numb_q    <= '0;
      sh_mask_q    <= '0;
      sh_err_q     <= 1'b0;
      numb_q       <= '0;
      mask_q       <= '1;
      err_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      digit_q      <= digit_d;
      dwell_q      <= dwell_d;
      clr_pend_q   <= clr_pend_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      active_q     <= active_d;
      gnt_src_q    <= gnt_src_d;
      sh_numb_q    <= sh_numb_d;
      sh_mask_q    <= sh_mask_d;
      sh_err_q     <= sh_err_d;
      numb_q       <= numb_d;
      mask_q       <= mask_d;
      err_q        <= err_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign numb        = numb_q;
  assign mask        = mask_q;
  assign error       = err_q;
  assign scan_en     = scan_w;
  assign digit       = digit_q;
  assign frame_start = frame_w;
  assign owner       = owner_q;
  assign active      = active_q;

endmodule
